// File: rtl/patterns_pkg.sv
// Shared types and default sizing for the Patterns frame sequencer.
package patterns_pkg;

  localparam int unsigned PIX_PER_LINE_DEF = 32;
  localparam int unsigned HBLANK_LEN_DEF   = 4;
  localparam int unsigned LINES_PER_FRAME  = 24;
  localparam int unsigned NUM_PATTERNS_DEF = 4;
  localparam int unsigned EOF_TIMEOUT_DEF  = 4;
  localparam int unsigned FPP_W            = 4;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PX_W_DEF  = cnt_w(PIX_PER_LINE_DEF);
  localparam int unsigned LY_W_DEF  = cnt_w(LINES_PER_FRAME);
  localparam int unsigned PID_W_DEF = cnt_w(NUM_PATTERNS_DEF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACTIVE    = 3'd1,
    S_HBLANK    = 3'd2,
    S_WAIT_EOF  = 3'd3,
    S_FRAME_END = 3'd4
  } state_t;

endpackage

// File: rtl/pattern_frame_sequencer_if.sv
// Pixel/frame timing bus between the sequencer, the line counter and the pattern datapath.
interface pattern_frame_sequencer_if
  import patterns_pkg::*;
#(
  parameter int unsigned PX_W  = PX_W_DEF,
  parameter int unsigned LY_W  = LY_W_DEF,
  parameter int unsigned PID_W = PID_W_DEF
) ();

  logic             lc_enb;
  logic             new_line;
  logic             end_frame;
  logic             pixel_valid;
  logic [PX_W-1:0]  pixel_x;
  logic [LY_W-1:0]  line_y;
  logic [PID_W-1:0] pattern_id;
  logic             frame_start;
  logic             frame_done;

  modport master (
    output lc_enb, new_line, pixel_valid, pixel_x, line_y, pattern_id, frame_start, frame_done,
    input  end_frame
  );

  modport slave (
    input  lc_enb, new_line, pixel_valid, pixel_x, line_y, pattern_id, frame_start, frame_done,
    output end_frame
  );

endinterface

// File: rtl/pattern_pixel_timer.sv
// Per-line pixel and h-blank counters with end-of-segment strobes.
module pattern_pixel_timer #(
  parameter int unsigned PIX_PER_LINE = 32,
  parameter int unsigned HBLANK_LEN   = 4,
  parameter int unsigned PX_W         = 5,
  parameter int unsigned BW           = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            blank,
  output logic [PX_W-1:0] pixel_x,
  output logic [BW-1:0]   blank_cnt,
  output logic            line_end_c,
  output logic            blank_end_c
);

  assign line_end_c  = active && (pixel_x == PX_W'(PIX_PER_LINE - 1));
  assign blank_end_c = blank && (blank_cnt == BW'(HBLANK_LEN - 1));

  // Counters sit at zero outside their own segment so each segment starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x   <= '0;
      blank_cnt <= '0;
    end else begin
      pixel_x   <= (active && !line_end_c) ? pixel_x + PX_W'(1) : '0;
      blank_cnt <= (blank && !blank_end_c) ? blank_cnt + BW'(1) : '0;
    end
  end

endmodule

// File: rtl/pattern_frame_sequencer.sv
// Frame-timing controller: line/pixel timing, line counter control, pattern stepping, sync checking.
module pattern_frame_sequencer
  import patterns_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE    = PIX_PER_LINE_DEF,
  parameter int unsigned HBLANK_LEN      = HBLANK_LEN_DEF,
  parameter int unsigned LINES_PER_FRAME = patterns_pkg::LINES_PER_FRAME,
  parameter int unsigned NUM_PATTERNS    = NUM_PATTERNS_DEF,
  parameter int unsigned EOF_TIMEOUT     = EOF_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [FPP_W-1:0]   frames_per_pat,
  output logic               busy,
  output logic               sync_err,
  pattern_frame_sequencer_if.master bus
);

  localparam int unsigned PX_W  = cnt_w(PIX_PER_LINE);
  localparam int unsigned LY_W  = cnt_w(LINES_PER_FRAME);
  localparam int unsigned PID_W = cnt_w(NUM_PATTERNS);
  localparam int unsigned BW    = cnt_w(HBLANK_LEN);
  localparam int unsigned TW    = cnt_w(EOF_TIMEOUT);

  state_t             state, state_nxt;
  logic [LY_W-1:0]    line_y, line_y_nxt;
  logic [PID_W-1:0]   pattern_id, pattern_id_nxt;
  logic [FPP_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [FPP_W-1:0]   fpp, fpp_nxt, fpp_last_c;
  logic [TW-1:0]      to_cnt, to_cnt_nxt;
  logic               stop_lat, stop_lat_nxt;
  logic               sync_err_nxt;
  logic               lc_enb, lc_enb_nxt;
  logic               new_line, new_line_nxt;
  logic               pixel_valid, pixel_valid_nxt;
  logic               frame_start, frame_start_nxt;
  logic               frame_done, frame_done_nxt;
  logic               busy_nxt;
  logic [PX_W-1:0]    pixel_x;
  logic [BW-1:0]      blank_cnt, blank_next;
  logic               line_end_c, blank_end_c;

  pattern_pixel_timer #(
    .PIX_PER_LINE (PIX_PER_LINE),
    .HBLANK_LEN   (HBLANK_LEN),
    .PX_W         (PX_W),
    .BW           (BW)
  ) u_pixel_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (state == S_ACTIVE),
    .blank       (state == S_HBLANK),
    .pixel_x     (pixel_x),
    .blank_cnt   (blank_cnt),
    .line_end_c  (line_end_c),
    .blank_end_c (blank_end_c)
  );

  // A captured frames_per_pat of zero behaves as one frame per pattern.
  assign fpp_last_c = (fpp == '0) ? '0 : fpp - FPP_W'(1);

  always_comb begin
    state_nxt      = state;
    line_y_nxt     = line_y;
    pattern_id_nxt = pattern_id;
    frame_cnt_nxt  = frame_cnt;
    fpp_nxt        = fpp;
    to_cnt_nxt     = '0;
    stop_lat_nxt   = stop_lat | (stop && (state != S_IDLE));
    sync_err_nxt   = sync_err | (bus.end_frame && ((state == S_ACTIVE) || (state == S_HBLANK)));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_ACTIVE;
          fpp_nxt        = frames_per_pat;
          sync_err_nxt   = 1'b0;
          pattern_id_nxt = '0;
          frame_cnt_nxt  = '0;
          line_y_nxt     = '0;
          stop_lat_nxt   = stop;
        end
      end
      S_ACTIVE: begin
        if (line_end_c) state_nxt = S_HBLANK;
      end
      S_HBLANK: begin
        if (blank_end_c) begin
          if (line_y < LY_W'(LINES_PER_FRAME - 1)) begin
            state_nxt  = S_ACTIVE;
            line_y_nxt = line_y + LY_W'(1);
          end else begin
            state_nxt = S_WAIT_EOF;
          end
        end
      end
      S_WAIT_EOF: begin
        if (bus.end_frame) begin
          state_nxt = S_FRAME_END;
        end else if (to_cnt == TW'(EOF_TIMEOUT - 1)) begin
          state_nxt    = S_FRAME_END;
          sync_err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      S_FRAME_END: begin
        line_y_nxt = '0;
        if (frame_cnt == fpp_last_c) begin
          frame_cnt_nxt  = '0;
          pattern_id_nxt = (pattern_id == PID_W'(NUM_PATTERNS - 1)) ? '0 : pattern_id + PID_W'(1);
        end else begin
          frame_cnt_nxt = frame_cnt + FPP_W'(1);
        end
        if (stop_lat || stop) begin
          state_nxt    = S_IDLE;
          stop_lat_nxt = 1'b0;
        end else begin
          state_nxt = S_ACTIVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Registered outputs are decoded from the upcoming state.
    blank_next      = ((state == S_HBLANK) && !blank_end_c) ? blank_cnt + BW'(1) : '0;
    lc_enb_nxt      = (state_nxt == S_ACTIVE) || (state_nxt == S_HBLANK) || (state_nxt == S_WAIT_EOF);
    pixel_valid_nxt = (state_nxt == S_ACTIVE);
    new_line_nxt    = (state_nxt == S_HBLANK) && (blank_next == BW'(HBLANK_LEN - 1));
    frame_start_nxt = (state_nxt == S_ACTIVE) && ((state == S_IDLE) || (state == S_FRAME_END));
    frame_done_nxt  = (state_nxt == S_FRAME_END);
    busy_nxt        = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      line_y      <= '0;
      pattern_id  <= '0;
      frame_cnt   <= '0;
      fpp         <= '0;
      to_cnt      <= '0;
      stop_lat    <= 1'b0;
      sync_err    <= 1'b0;
      lc_enb      <= 1'b0;
      new_line    <= 1'b0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_y      <= line_y_nxt;
      pattern_id  <= pattern_id_nxt;
      frame_cnt   <= frame_cnt_nxt;
      fpp         <= fpp_nxt;
      to_cnt      <= to_cnt_nxt;
      stop_lat    <= stop_lat_nxt;
      sync_err    <= sync_err_nxt;
      lc_enb      <= lc_enb_nxt;
      new_line    <= new_line_nxt;
      pixel_valid <= pixel_valid_nxt;
      frame_start <= frame_start_nxt;
      frame_done  <= frame_done_nxt;
      busy        <= busy_nxt;
    end
  end

  assign bus.lc_enb      = lc_enb;
  assign bus.new_line    = new_line;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_x     = pixel_x;
  assign bus.line_y      = line_y;
  assign bus.pattern_id  = pattern_id;
  assign bus.frame_start = frame_start;
  assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_pattern_frame_sequencer.sv
// Bench for pattern_frame_sequencer: 8-pixel lines, 2-cycle blank, behavioural 24-line counter.
module tb_pattern_frame_sequencer;

  localparam int unsigned PIX = 8;
  localparam int unsigned HB  = 2;
  localparam int unsigned LPF = 24;
  localparam int NOM_LEN  = 241;  // frame_start cycle to frame_done cycle, nominal
  localparam int TO_LEN   = 244;  // same with 4 WAIT_EOF cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] fpp = 4'd0;
  logic       busy, sync_err;
  int         total = 0;
  int         bad = 0;
  int         force_mode = 0;
  logic [5:0] lc_cnt;

  typedef struct {
    int pid;
    int nl;
    int pv;
    int se;
    int len;
  } exp_t;
  exp_t q[$];

  pattern_frame_sequencer_if #(.PX_W(3), .LY_W(5), .PID_W(2)) bus ();

  pattern_frame_sequencer #(
    .PIX_PER_LINE    (PIX),
    .HBLANK_LEN      (HB),
    .LINES_PER_FRAME (LPF),
    .NUM_PATTERNS    (4),
    .EOF_TIMEOUT     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .frames_per_pat (fpp),
    .busy           (busy),
    .sync_err       (sync_err),
    .bus            (bus)
  );

  always #8 clk = ~clk;

  // Behavioural line counter: cleared by lc_enb low, counts new_line pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            lc_cnt <= '0;
    else if (!bus.lc_enb)  lc_cnt <= '0;
    else if (bus.new_line) lc_cnt <= lc_cnt + 6'd1;
  end
  assign bus.end_frame = (force_mode == 1) ? 1'b0 :
                         (force_mode == 2) ? 1'b1 : (lc_cnt == 6'(LPF));

  function automatic logic [16:0] outs();
    return {bus.lc_enb, bus.new_line, bus.pixel_valid, bus.pixel_x, bus.line_y,
            bus.pattern_id, bus.frame_start, bus.frame_done, busy, sync_err};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int pid, input int se, input int len);
    exp_t e;
    e.pid = pid; e.nl = LPF; e.pv = LPF * PIX; e.se = se; e.len = len;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.frame_done) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pos(input string name, input int y, input int x, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.pixel_valid && bus.line_y == 5'(y) && bus.pixel_x == 3'(x)) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: per-frame statistics checked against the scoreboard at each frame_done.
  initial begin
    int   cyc = 0;
    int   st = 0;
    int   nl = 0;
    int   pv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        nl = 0;
        pv = 0;
        continue;
      end
      if (bus.frame_start) begin
        st = cyc;
        nl = 0;
        pv = 0;
      end
      if (bus.new_line)    nl++;
      if (bus.pixel_valid) pv++;
      if (bus.frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pattern_id", int'(bus.pattern_id), e.pid);
          chk("new_lines", nl, e.nl);
          chk("pixel_cycles", pv, e.pv);
          chk("sync_err_at_done", int'(sync_err), e.se);
          chk("frame_len", cyc - st, e.len);
        end
      end
    end
  end

  initial begin
    // Reset and idle.
    tick(1);
    chk("reset_outputs", int'(outs()), 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_outputs", int'(outs()), 0);
    end

    // Nominal streaming, two frames per pattern; mid-run start/fpp changes ignored.
    fpp = 4'd2;
    for (int i = 0; i < 9; i++) push((i / 2) % 4, 0, NOM_LEN);
    pulse_start(1'b0);
    chk("t2_frame_start", int'(bus.frame_start), 1);
    chk("t2_busy", int'(busy), 1);
    tick(50);
    start = 1'b1;
    fpp   = 4'd0;
    tick(2);
    start = 1'b0;
    for (int i = 0; i < 8; i++) wait_done("t2_frame", 300);

    // Stop mid-frame: frame completes, then idle.
    wait_pos("t3_line10", 10, 0, 300);
    pulse_stop();
    wait_done("t3_frame", 300);
    tick(1);
    chk("t3_busy_after_stop", int'(busy), 0);
    chk("t3_lc_enb_after_stop", int'(bus.lc_enb), 0);
    chk("t3_pattern_held", int'(bus.pattern_id), 0);
    tick(20);
    chk("t3_still_idle", int'(busy), 0);

    // Missing end_frame: timeout, sync_err set, streaming continues.
    force_mode = 1;
    fpp = 4'd1;
    push(0, 1, TO_LEN);
    push(1, 1, NOM_LEN);
    pulse_start(1'b0);
    chk("t4_sync_clear_on_start", int'(sync_err), 0);
    wait_done("t4_frame0", 300);
    force_mode = 0;
    wait_pos("t4_line3", 3, 0, 300);
    pulse_stop();
    wait_done("t4_frame1", 300);
    tick(1);
    chk("t4_idle", int'(busy), 0);
    chk("t4_sync_sticky_idle", int'(sync_err), 1);

    // Early end_frame: sync_err set and sticky; next accepted start clears it.
    push(0, 1, NOM_LEN);
    pulse_start(1'b0);
    chk("t5_sync_clear_on_start", int'(sync_err), 0);
    wait_pos("t5_line5", 5, 2, 300);
    force_mode = 2;
    tick(1);
    chk("t5_sync_set", int'(sync_err), 1);
    tick(2);
    force_mode = 0;
    pulse_stop();
    wait_done("t5_frame", 300);
    tick(1);
    chk("t5_sync_sticky", int'(sync_err), 1);
    push(0, 0, NOM_LEN);
    pulse_start(1'b1);
    chk("t5_sync_cleared", int'(sync_err), 0);
    wait_done("t5_one_frame", 300);
    tick(1);
    chk("t5_one_frame_idle", int'(busy), 0);

    // Asynchronous reset mid-line.
    fpp = 4'd2;
    pulse_start(1'b0);
    wait_pos("t6_pos", 7, 3, 300);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", int'(outs()), 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // frames_per_pat = 0 behaves as 1.
    fpp = 4'd0;
    push(0, 0, NOM_LEN);
    push(1, 0, NOM_LEN);
    push(2, 0, NOM_LEN);
    pulse_start(1'b0);
    chk("t7_pattern0", int'(bus.pattern_id), 0);
    chk("t7_line0", int'(bus.line_y), 0);
    chk("t7_frame_start", int'(bus.frame_start), 1);
    wait_done("t7_frame0", 300);
    wait_done("t7_frame1", 300);
    wait_pos("t7_line2", 2, 0, 300);
    pulse_stop();
    wait_done("t7_frame2", 300);
    tick(1);
    chk("t7_idle", int'(busy), 0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
